// File: rtl/tp_input_monitor_if.sv
// Bus bundle for the test-point input monitor: raw pin inputs, counter
// control, snapshot readback and the per-channel status outputs.
interface tp_input_monitor_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
);
  logic [NCH-1:0]   TP_IN;
  logic             CLR_CNT;
  logic             SNAP;
  logic [1:0]       RD_SEL;
  logic [CNT_W-1:0] RD_DATA;
  logic [NCH-1:0]   LEVEL;
  logic [NCH-1:0]   RISE;
  logic [NCH-1:0]   OVF;
  logic             SNAP_VALID;

  // Firmware / bench side: drives pins and controls, observes status.
  modport master (
    output TP_IN, CLR_CNT, SNAP, RD_SEL,
    input  RD_DATA, LEVEL, RISE, OVF, SNAP_VALID
  );

  // Monitor side.
  modport slave (
    input  TP_IN, CLR_CNT, SNAP, RD_SEL,
    output RD_DATA, LEVEL, RISE, OVF, SNAP_VALID
  );
endinterface

// File: rtl/tp_input_monitor.sv
// Test-point input monitor. Each tri-stated test-point pin is synchronized
// to CLK, glitch-filtered, and its filtered rising edges are counted.
// Firmware can clear the live counters and snapshot them into a bank that
// is read back one channel at a time.
// Channel mapping: {TP_B35[10], TP_B35[9], TP_B26[1], TP_B26[0]}.
module tp_input_monitor #(
  parameter int NCH      = 4,
  parameter int FILT_LEN = 4,   // 1..15
  parameter int CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  tp_input_monitor_if.slave bus
);

  // Stability count at which a disagreeing value is accepted.
  localparam logic [3:0]       FC_LAST = 4'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NCH-1:0]   s1_q;
  logic [NCH-1:0]   s2_q;
  logic [NCH-1:0]   level_w;
  logic [NCH-1:0]   rise_w;
  logic [NCH-1:0]   ovf_w;
  logic [CNT_W-1:0] cnt_w  [NCH];
  logic [CNT_W-1:0] snap_q [NCH];
  logic             snap_valid_q;
  logic [CNT_W-1:0] rd_data_q;

  // Two-flop synchronizer for the asynchronous pin inputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.TP_IN;
      s2_q <= s1_q;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [3:0]       fc_q, fc_d;
    logic             lvl_q, lvl_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Glitch filter: a new value must persist FILT_LEN cycles before the
    // filtered level takes it; any return to the current level restarts it.
    always_comb begin
      fc_d  = fc_q;
      lvl_d = lvl_q;
      if (s2_q[gi] == lvl_q) begin
        fc_d = '0;
      end else if (fc_q == FC_LAST) begin
        lvl_d = s2_q[gi];
        fc_d  = '0;
      end else begin
        fc_d = fc_q + 4'd1;
      end
    end

    // RISE is registered together with the level so both change on the same edge.
    assign rise_d = lvl_d & ~lvl_q;

    // Live edge counter: saturates at max and flags the lost increment;
    // a clear coinciding with a rise keeps that rise as the first count.
    always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (bus.CLR_CNT) begin
        cnt_d = rise_q ? CNT_W'(1) : '0;
        ovf_d = 1'b0;
      end else if (rise_q) begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
    end

    // Per-channel filter, edge and counter state.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        fc_q   <= '0;
        lvl_q  <= 1'b0;
        rise_q <= 1'b0;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        fc_q   <= fc_d;
        lvl_q  <= lvl_d;
        rise_q <= rise_d;
        cnt_q  <= cnt_d;
        ovf_q  <= ovf_d;
      end
    end

    assign level_w[gi] = lvl_q;
    assign rise_w[gi]  = rise_q;
    assign ovf_w[gi]   = ovf_q;
    assign cnt_w[gi]   = cnt_q;
  end

  // Snapshot bank takes the pre-edge live counts; readback is registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        snap_q[i] <= '0;
      end
      snap_valid_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      if (bus.SNAP) begin
        for (int i = 0; i < NCH; i++) begin
          snap_q[i] <= cnt_w[i];
        end
        snap_valid_q <= 1'b1;
      end
      rd_data_q <= snap_q[bus.RD_SEL];
    end
  end

  assign bus.LEVEL      = level_w;
  assign bus.RISE       = rise_w;
  assign bus.OVF        = ovf_w;
  assign bus.SNAP_VALID = snap_valid_q;
  assign bus.RD_DATA    = rd_data_q;

endmodule

// File: tb/tb_tp_input_monitor.sv
// Bench for tp_input_monitor: directed scenarios plus randomized pin
// activity, checked every cycle against a window-based reference model.
module tb_tp_input_monitor;
  localparam int NCH      = 4;
  localparam int FILT_LEN = 4;
  localparam int CNT_W    = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;
  localparam int HLEN     = FILT_LEN + 2;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  tp_input_monitor_if #(.NCH(NCH), .CNT_W(CNT_W)) bus();

  tp_input_monitor #(.NCH(NCH), .FILT_LEN(FILT_LEN), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit align_chk = 1'b0;

  // Reference model state: pin history (index 0 = newest sampled value).
  bit hist    [NCH][HLEN];
  bit lvl_m   [NCH];
  bit rise_m  [NCH];
  bit ovf_m   [NCH];
  int cnt_m   [NCH];
  int snap_m  [NCH];
  bit snapv_m;
  int rd_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int j = 0; j < HLEN; j++) hist[c][j] = 1'b0;
      lvl_m[c] = 0; rise_m[c] = 0; ovf_m[c] = 0; cnt_m[c] = 0; snap_m[c] = 0;
    end
    snapv_m = 0;
    rd_m    = 0;
  endtask

  // One clock edge of the reference behaviour, given the inputs seen at that edge.
  // The level flips once the pin sampled 2..FILT_LEN+1 edges ago has
  // disagreed with it on every one of those FILT_LEN consecutive samples.
  task automatic model_edge(input logic [NCH-1:0] tp, input logic clr, input logic snp,
                            input logic [1:0] sel);
    bit all_diff;
    rd_m = snap_m[sel];
    if (snp) begin
      for (int c = 0; c < NCH; c++) snap_m[c] = cnt_m[c];
      snapv_m = 1;
    end
    for (int c = 0; c < NCH; c++) begin
      if (clr) begin
        cnt_m[c] = rise_m[c] ? 1 : 0;
        ovf_m[c] = 0;
      end else if (rise_m[c]) begin
        if (cnt_m[c] == CMAX) ovf_m[c] = 1;
        else cnt_m[c] = cnt_m[c] + 1;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      for (int j = HLEN - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
      hist[c][0] = tp[c];
      all_diff = 1;
      for (int j = 2; j < HLEN; j++) if (hist[c][j] == lvl_m[c]) all_diff = 0;
      rise_m[c] = all_diff && !lvl_m[c];
      if (all_diff) lvl_m[c] = !lvl_m[c];
    end
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] l, r, o;
    for (int c = 0; c < NCH; c++) begin
      l[c] = lvl_m[c]; r[c] = rise_m[c]; o[c] = ovf_m[c];
    end
    check_eq("level", bus.LEVEL, l);
    check_eq("rise", bus.RISE, r);
    check_eq("ovf", bus.OVF, o);
    check_eq("snap_valid", bus.SNAP_VALID, snapv_m);
    check_eq("rd_data", bus.RD_DATA, rd_m);
    if (align_chk && bus.RISE != '0) check_eq("rise_align", bus.RISE, {NCH{1'b1}});
  endtask

  task automatic check_zero(input string pfx);
    check_eq({pfx, "_level"}, bus.LEVEL, 0);
    check_eq({pfx, "_rise"}, bus.RISE, 0);
    check_eq({pfx, "_ovf"}, bus.OVF, 0);
    check_eq({pfx, "_snap_valid"}, bus.SNAP_VALID, 0);
    check_eq({pfx, "_rd_data"}, bus.RD_DATA, 0);
  endtask

  task automatic step();
    logic [NCH-1:0] tp;
    logic clr, snp;
    logic [1:0] sel;
    tp = bus.TP_IN; clr = bus.CLR_CNT; snp = bus.SNAP; sel = bus.RD_SEL;
    @(posedge CLK);
    model_edge(tp, clr, snp, sel);
    #1;
    check_outputs();
  endtask

  task automatic pulse(input logic [NCH-1:0] mask, input int hi, input int lo);
    bus.TP_IN = bus.TP_IN | mask;
    repeat (hi) step();
    bus.TP_IN = bus.TP_IN & ~mask;
    repeat (lo) step();
  endtask

  task automatic strobe_clr();
    bus.CLR_CNT = 1'b1; step(); bus.CLR_CNT = 1'b0;
  endtask

  // Snapshot, then read one channel two edges later.
  task automatic snap_read(input logic [1:0] sel, input int exp, input string tag);
    bus.RD_SEL = sel; bus.SNAP = 1'b1; step(); bus.SNAP = 1'b0; step();
    check_eq(tag, bus.RD_DATA, exp);
  endtask

  // Assert reset mid-cycle, optionally toggling pins, release at a falling edge.
  task automatic async_reset(input logic [NCH-1:0] tp_after, input bit toggle);
    #2 RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      if (toggle) bus.TP_IN = NCH'($urandom);
      check_zero("in_reset");
    end
    @(negedge CLK);
    bus.TP_IN = tp_after;
    RST = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [NCH-1:0] pins;
    int hold [NCH];

    bus.TP_IN = '0; bus.CLR_CNT = 1'b0; bus.SNAP = 1'b0; bus.RD_SEL = '0;
    model_reset();

    // Power-on reset.
    #1 RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 check_zero("init");
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) step();

    // Reset while a channel is filtered high and counted.
    pulse(4'b0001, 4, 6);
    async_reset('0, 1'b1);
    repeat (8) step();

    // Glitch rejection: 3-cycle pulse is discarded.
    pulse(4'b0001, 3, 10);
    check_eq("glitch_level0", bus.LEVEL[0], 0);

    // 4-cycle pulse: level and RISE at edge 6, RISE for exactly one cycle.
    bus.TP_IN = 4'b0001;
    repeat (4) step();
    bus.TP_IN = '0;
    step();
    check_eq("edge5_level0", bus.LEVEL[0], 0);
    step();
    check_eq("edge6_level0", bus.LEVEL[0], 1);
    check_eq("edge6_rise0", bus.RISE[0], 1);
    step();
    check_eq("edge7_rise0", bus.RISE[0], 0);
    repeat (6) step();
    snap_read(2'd0, 1, "min_pulse_count");
    check_eq("snap_valid_set", bus.SNAP_VALID, 1);

    // Counting and readback on channel 2.
    strobe_clr();
    repeat (10) pulse(4'b0100, 8, 8);
    snap_read(2'd2, 10, "count_ch2");
    for (int s = 0; s < 4; s++) begin
      if (s != 2) begin
        bus.RD_SEL = 2'(s); step();
        check_eq("count_other", bus.RD_DATA, 0);
      end
    end

    // Saturation on channel 1 at the minimum counted pulse shape.
    strobe_clr();
    repeat (17) pulse(4'b0010, FILT_LEN, FILT_LEN);
    repeat (4) step();
    check_eq("sat_ovf1", bus.OVF[1], 1);
    snap_read(2'd1, CMAX, "sat_count");
    strobe_clr();
    check_eq("clr_ovf1", bus.OVF[1], 0);
    snap_read(2'd1, 0, "clr_count");

    // SNAP together with CLR_CNT keeps the pre-clear value.
    repeat (5) pulse(4'b1000, 8, 8);
    repeat (4) step();
    bus.RD_SEL = 2'd3; bus.SNAP = 1'b1; bus.CLR_CNT = 1'b1; step();
    bus.SNAP = 1'b0; bus.CLR_CNT = 1'b0; step();
    check_eq("snap_clr_snapshot", bus.RD_DATA, 5);
    snap_read(2'd3, 0, "snap_clr_live");

    // CLR_CNT coincident with RISE leaves a count of 1.
    repeat (2) pulse(4'b1000, 8, 8);
    bus.TP_IN = 4'b1000;
    repeat (4) step();
    bus.TP_IN = '0;
    repeat (2) step();
    check_eq("clr_rise_pre", bus.RISE[3], 1);
    strobe_clr();
    repeat (2) step();
    snap_read(2'd3, 1, "clr_rise_count");

    // Identical pulse trains on all channels.
    strobe_clr();
    align_chk = 1'b1;
    repeat (3) pulse({NCH{1'b1}}, 6, 6);
    align_chk = 1'b0;
    for (int s = 0; s < NCH; s++) snap_read(2'(s), 3, "multi_count");

    // Pin held high through reset: one RISE FILT_LEN+2 edges after release.
    bus.TP_IN = 4'b1000;
    step();
    async_reset(4'b1000, 1'b0);
    for (int e = 1; e <= FILT_LEN + 4; e++) begin
      step();
      check_eq("hold_high_rise", bus.RISE[3], (e == FILT_LEN + 2) ? 1 : 0);
    end
    bus.TP_IN = '0;
    repeat (8) step();

    // Randomized pin activity with sporadic SNAP/CLR and readback.
    pins = '0;
    for (int c = 0; c < NCH; c++) hold[c] = 0;
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (hold[c] == 0) begin
          pins[c] = ~pins[c];
          hold[c] = $urandom_range(1, 10);
        end
        hold[c]--;
      end
      bus.TP_IN   = pins;
      bus.SNAP    = ($urandom_range(0, 15) == 0);
      bus.CLR_CNT = ($urandom_range(0, 63) == 0);
      bus.RD_SEL  = 2'($urandom_range(0, 3));
      step();
      if (i == 1200) begin
        bus.SNAP = 1'b0; bus.CLR_CNT = 1'b0;
        async_reset(pins, 1'b0);
      end
    end
    bus.SNAP = 1'b0; bus.CLR_CNT = 1'b0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
